dec_code_seq: RTL and testbench
===============================

// Module: dec_code_seq
// PURPOSE
//   Upstream stage of the 3-to-8 decoder / function block. Generates the 3-bit select code
//   {a,b,c} that the decoder expands into d0..d7 and f1..f3.
//   Steps through codes in binary-up, binary-down, Gray or single-pass order.
//   Each code is offered on a valid/ready handshake, with a programmable dwell gap between codes.
// PARAMETERS
//   DWELL_W        4   width of dwell counter / dwell input
//   (no others; code width fixed at 3)
// PORTS
//   clk         in   1        rising-edge clock, sole clock
//   rst         in   1        synchronous, active-high reset
//   start       in   1        begin sequencing (honoured in IDLE only)
//   stop        in   1        abort sequencing (any state)
//   mode        in   2        00 bin-up, 01 bin-down, 10 Gray-up, 11 single pass bin-up
//   load_en     in   1        load starting count (honoured in IDLE only)
//   load_code   in   3        starting count value
//   dwell       in   DWELL_W  idle cycles between accepted code and next offer; 0 = back-to-back
//   code_ready  in   1        downstream accepts code this cycle
//   a,b,c       out  1 each   code bits, a = MSB; drive decoder inputs directly
//   code_valid  out  1        {a,b,c} valid
//   busy        out  1        state != IDLE
//   wrap        out  1        1-cycle pulse: count wrapped (7->0 up, 0->7 down)
//   done        out  1        1-cycle pulse: single-pass mode finished
// BEHAVIOUR
//   Reset: state IDLE, count=0, a=b=c=0, code_valid=0, busy=0, wrap=0, done=0.
//   All outputs are registered; no combinational path from inputs to outputs.
//   States: IDLE, EMIT, DWELL.
//   - mode and dwell are latched on start; later changes are ignored until the next IDLE.
//   - Code = count, except Gray mode: code = count ^ (count>>1).
//   IDLE:
//     - load_en: count <= load_code.
//     - load_en with start in the same cycle: the loaded value is the first code emitted.
//     - start: go to EMIT, code_valid=1 from the next cycle.
//   EMIT:
//     - code_valid=1; {a,b,c} held stable until the handshake (valid & ready).
//     - On handshake: count advances (+1, or -1 in mode 01, mod 8).
//     - latched dwell==0: stay in EMIT, next code offered the following cycle.
//     - latched dwell!=0: go to DWELL, dcnt <= dwell, code_valid=0.
//   DWELL:
//     - code_valid=0; dcnt decrements each cycle.
//     - When dcnt==1, go to EMIT. The gap between codes is exactly dwell cycles.
//   wrap pulses on the cycle after the handshake whose advance crosses 7->0 or 0->7.
//   Single pass (mode 11):
//     - Exactly 8 handshakes starting from the current count; the count advances modulo 8.
//     - After the 8th handshake: done=1 for one cycle, go to IDLE.
//     - Count ends equal to its start value; wrap still pulses.
//   stop (highest priority after rst):
//     - In EMIT without handshake: go to IDLE, code_valid drops next cycle, count unchanged.
//     - Handshake and stop in the same cycle: the transfer counts, count advances, go to IDLE.
//     - In DWELL: go to IDLE immediately, dwell abandoned.
//     - stop and start together in IDLE: remain in IDLE.
//   rst mid-operation returns every output to its reset value on the next edge.
//   {a,b,c} hold their last value in IDLE and DWELL.
// CONFIGURATION
//   SEQ_SKIP_EN defined:
//     - Adds input skip_mask [7:0]; a bit=1 means that code value is never offered.
//     - The advance moves to the next unmasked code in the current direction (up to 7 steps, same cycle).
//     - If start finds the current code masked, the first code offered is the next unmasked one.
//     - skip_mask==8'hFF: start is ignored.
//     - Single pass: counts unmasked codes only; done fires after the last unmasked code.
//     - wrap pulses when the skip crosses the 7/0 boundary.
//     - skip_mask is sampled live; it is not latched.
//   SEQ_SKIP_EN undefined: port absent, all 8 codes offered; behaviour otherwise identical.
// TESTING
//   1 Reset: rst=1 for 2 cycles with start=1 -> a,b,c=000, valid/busy/wrap/done=0; remain IDLE.
//   2 Mode 00, dwell=0, ready=1, start -> codes 0,1,...,7,0 on consecutive cycles;
//     wrap pulses one cycle after code 7 accepted.
//   3 Mode 10, load_code=5 with start, dwell=2, ready=1 -> Gray codes 111,101,100,...;
//     valid high 1 cycle, low 2 cycles between offers.
//   4 Mode 01, ready=0 for 4 cycles then 1 -> code 000 held stable with valid=1 all 4 cycles;
//     next code 111, wrap pulses.
//   5 Mode 11 from count 3 -> 8 transfers 3..7,0,1,2; done one cycle later;
//     busy=0, count=3.
//   6 stop with handshake in EMIT -> IDLE, count advanced;
//     stop in DWELL -> IDLE, no extra offer.
//     SEQ_SKIP_EN, mask=8'h0A, mode 00 -> 0,2,4,5,6,7,0.

Source files
------------

// File: rtl/dec_code_seq.sv
// dec_code_seq: select-code sequencer feeding the 3-to-8 decoder / function block.
// Walks a 3-bit count in binary-up, binary-down, Gray-up or single-pass binary-up
// order and offers each code {a,b,c} on a valid/ready handshake. A programmable
// dwell gap can be inserted between an accepted code and the next offer.
//
// Ports:
//   clk, rst        rising-edge clock; synchronous active-high reset
//   start, stop     begin sequencing (IDLE only) / abort sequencing (any state)
//   mode[1:0]       00 bin-up, 01 bin-down, 10 Gray-up, 11 single pass bin-up
//   load_en         load load_code into the count (IDLE only)
//   load_code[2:0]  starting count
//   dwell[DWELL_W]  idle cycles between an accepted code and the next offer
//   code_ready      downstream accepts the offered code
//   a, b, c         code bits (a = MSB), registered
//   code_valid      {a,b,c} valid, registered
//   busy            sequencer not idle, registered
//   wrap            one-cycle pulse after an advance that crossed 7/0
//   done            one-cycle pulse when a single pass completes
//
// Build option: define SEQ_SKIP_EN to add skip_mask[7:0]; masked code values are
// never offered and the advance jumps to the next unmasked code.
module dec_code_seq #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               load_en,
  input  logic [2:0]         load_code,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               code_ready,
`ifdef SEQ_SKIP_EN
  input  logic [7:0]         skip_mask,
`endif
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               code_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = CODE_W + 1;
  localparam int unsigned NCODES = 1 << CODE_W;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_ONCE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t              state;
  logic [CODE_W-1:0]   count;
  logic [1:0]          mode_q;
  logic [DWELL_W-1:0]  dwell_q;
  logic [DWELL_W-1:0]  dcnt;
  logic [CNT_W-1:0]    hs_cnt;

  logic [NCODES-1:0]   mask_c;
  logic [CODE_W-1:0]   seed_c;
  logic [CODE_W-1:0]   first_c;
  logic [CODE_W-1:0]   adv_c;
  logic                adv_wrap_c;
  logic                handshake_c;
  logic                last_c;
  logic                all_masked_c;
  logic [CNT_W-1:0]    n_open_c;

`ifdef SEQ_SKIP_EN
  assign mask_c = skip_mask;
`else
  assign mask_c = '0;
`endif

  // Offered code for a given count.
  function automatic logic [CODE_W-1:0] code_of(input logic [CODE_W-1:0] cnt,
                                                input logic              gray);
    return gray ? (cnt ^ (cnt >> 1)) : cnt;
  endfunction

  // Nearest count in the given direction whose code is not masked.
  function automatic logic [CODE_W-1:0] step_to(input logic [CODE_W-1:0] from,
                                                input logic              down,
                                                input logic              gray,
                                                input logic [NCODES-1:0] mask);
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] res;
    logic              found;
    found = 1'b0;
    res   = from;
    for (int i = 1; i <= int'(NCODES); i++) begin
      cand = down ? (from - CODE_W'(i)) : (from + CODE_W'(i));
      if (!found && !mask[code_of(cand, gray)]) begin
        found = 1'b1;
        res   = cand;
      end
    end
    return res;
  endfunction

  // Start seed, advance target and single-pass bookkeeping.
  always_comb begin
    seed_c       = load_en ? load_code : count;
    first_c      = mask_c[code_of(seed_c, mode == MODE_GRAY)]
                 ? step_to(seed_c, mode == MODE_DOWN, mode == MODE_GRAY, mask_c)
                 : seed_c;
    adv_c        = step_to(count, mode_q == MODE_DOWN, mode_q == MODE_GRAY, mask_c);
    // Landing at or past the start in the travel direction means the 7/0 edge was crossed.
    adv_wrap_c   = (mode_q == MODE_DOWN) ? (adv_c >= count) : (adv_c <= count);
    all_masked_c = &mask_c;
    n_open_c     = CNT_W'($countones(~mask_c));
    handshake_c  = (state == EMIT) && code_valid && code_ready;
    last_c       = (mode_q == MODE_ONCE) && ((hs_cnt + CNT_W'(1)) >= n_open_c);
  end

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      mode_q     <= '0;
      dwell_q    <= '0;
      dcnt       <= '0;
      hs_cnt     <= '0;
      {a, b, c}  <= '0;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && !all_masked_c) begin
            state      <= EMIT;
            mode_q     <= mode;
            dwell_q    <= dwell;
            hs_cnt     <= '0;
            count      <= first_c;
            {a, b, c}  <= code_of(first_c, mode == MODE_GRAY);
            code_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (load_en) begin
            count <= load_code;
          end
        end
        EMIT: begin
          if (handshake_c) begin
            count  <= adv_c;
            wrap   <= adv_wrap_c;
            hs_cnt <= hs_cnt + CNT_W'(1);
            if (stop || last_c) begin
              state      <= IDLE;
              code_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= last_c;
            end else if (dwell_q == '0) begin
              {a, b, c} <= code_of(adv_c, mode_q == MODE_GRAY);
            end else begin
              state      <= DWELL;
              dcnt       <= dwell_q;
              code_valid <= 1'b0;
            end
          end else if (stop) begin
            state      <= IDLE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        DWELL: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dcnt == DWELL_W'(1)) begin
            state      <= EMIT;
            code_valid <= 1'b1;
            {a, b, c}  <= code_of(count, mode_q == MODE_GRAY);
          end else begin
            dcnt <= dcnt - DWELL_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          code_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_code_seq.sv
// tb_dec_code_seq: self-checking bench for dec_code_seq. Directed scenarios plus
// randomized runs checked against a transaction-level model (expected code list,
// dwell gap length, wrap/done timing).
module tb_dec_code_seq;

  localparam int unsigned DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b1;
  logic               stop = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic               load_en = 1'b0;
  logic [2:0]         load_code = 3'd0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               code_ready = 1'b0;
`ifdef SEQ_SKIP_EN
  logic [7:0]         skip_mask = 8'h00;
`endif
  logic a, b, c, code_valid, busy, wrap, done;
  logic [2:0] abc;

  int tests_run = 0;
  int fails = 0;

  assign abc = {a, b, c};

  always #5 clk = ~clk;

  dec_code_seq #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .load_en   (load_en),
    .load_code (load_code),
    .dwell     (dwell),
    .code_ready(code_ready),
`ifdef SEQ_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .a         (a),
    .b         (b),
    .c         (c),
    .code_valid(code_valid),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  function automatic logic [2:0] gray3(input logic [2:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, optionally loading a starting count.
  task automatic begin_run(input logic [1:0] m, input logic [2:0] s,
                           input logic [DWELL_W-1:0] d, input logic ld);
    mode = m; load_code = s; dwell = d; load_en = ld; start = 1'b1;
    tick();
    start = 1'b0; load_en = 1'b0;
  endtask

  task automatic halt();
    code_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    tests_run++;
    if ({abc, code_valid, busy, wrap, done} !== 7'b0) begin
      fails++;
      $display("FAIL reset: abc=%b valid=%b busy=%b wrap=%b done=%b, want all 0",
               abc, code_valid, busy, wrap, done);
    end
    start = 1'b0; rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b, want 0 0", busy, code_valid);
    end
  endtask

  task automatic test_bin_up();
    code_ready = 1'b1;
    begin_run(2'b00, 3'd0, '0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (code_valid !== 1'b1 || abc !== 3'(k) || wrap !== (k == 8)) begin
        fails++;
        $display("FAIL bin_up[%0d]: valid=%b abc=%b wrap=%b, want 1 %b %b",
                 k, code_valid, abc, wrap, 3'(k), (k == 8));
      end
      if (k < 8) tick();
    end
    halt();
    tests_run++;
    if (code_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bin_up_stop: valid=%b busy=%b, want 0 0", code_valid, busy);
    end
  endtask

  task automatic test_gray_dwell();
    code_ready = 1'b1;
    begin_run(2'b10, 3'd5, DWELL_W'(2), 1'b1);
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if (code_valid !== 1'b1 || abc !== gray3(3'(5 + j)) || wrap !== 1'b0) begin
        fails++;
        $display("FAIL gray_offer[%0d]: valid=%b abc=%b wrap=%b, want 1 %b 0",
                 j, code_valid, abc, wrap, gray3(3'(5 + j)));
      end
      tick();
      for (int g = 0; g < 2; g++) begin
        tests_run++;
        if (code_valid !== 1'b0 || wrap !== (j == 2 && g == 0)) begin
          fails++;
          $display("FAIL gray_gap[%0d.%0d]: valid=%b wrap=%b, want 0 %b",
                   j, g, code_valid, wrap, (j == 2 && g == 0));
        end
        tick();
      end
    end
    tests_run++;
    if (code_valid !== 1'b1 || abc !== 3'b000) begin
      fails++;
      $display("FAIL gray_after_wrap: valid=%b abc=%b, want 1 000", code_valid, abc);
    end
    halt();
  endtask

  task automatic test_down_stall();
    code_ready = 1'b0;
    begin_run(2'b01, 3'd0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (code_valid !== 1'b1 || abc !== 3'b000 || wrap !== 1'b0) begin
        fails++;
        $display("FAIL down_hold[%0d]: valid=%b abc=%b wrap=%b, want 1 000 0",
                 i, code_valid, abc, wrap);
      end
      if (i < 3) tick();
    end
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    tests_run++;
    if (code_valid !== 1'b1 || abc !== 3'b111 || wrap !== 1'b1) begin
      fails++;
      $display("FAIL down_next: valid=%b abc=%b wrap=%b, want 1 111 1", code_valid, abc, wrap);
    end
    halt();
  endtask

  task automatic test_single_pass();
    logic [2:0] cnt;
    logic       exp_wrap;
    int         hs, cyc;
    cnt = 3'd3; exp_wrap = 1'b0; hs = 0; cyc = 0;
    begin_run(2'b11, 3'd3, DWELL_W'($urandom_range(0, 2)), 1'b1);
    while (hs < 8 && cyc < 200) begin
      tests_run++;
      if (done !== 1'b0 || wrap !== exp_wrap || (code_valid === 1'b1 && abc !== cnt)) begin
        fails++;
        $display("FAIL single_step[%0d]: done=%b wrap=%b valid=%b abc=%b, want 0 %b - %b",
                 hs, done, wrap, code_valid, abc, exp_wrap, cnt);
      end
      exp_wrap = 1'b0;
      code_ready = ($urandom_range(0, 2) != 0);
      if (code_valid === 1'b1 && code_ready) begin
        exp_wrap = (cnt == 3'd7);
        cnt = cnt + 3'd1;
        hs++;
      end
      tick();
      cyc++;
    end
    code_ready = 1'b0;
    tests_run++;
    if (hs != 8 || done !== 1'b1 || busy !== 1'b0 || code_valid !== 1'b0 || wrap !== exp_wrap) begin
      fails++;
      $display("FAIL single_done: transfers=%0d done=%b busy=%b valid=%b wrap=%b, want 8 1 0 0 %b",
               hs, done, busy, code_valid, wrap, exp_wrap);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b, want 0", done);
    end
    begin_run(2'b00, 3'd0, '0, 1'b0);
    tests_run++;
    if (code_valid !== 1'b1 || abc !== 3'd3) begin
      fails++;
      $display("FAIL single_count: valid=%b abc=%b, want 1 011", code_valid, abc);
    end
    halt();
  endtask

  task automatic test_stop();
    code_ready = 1'b0;
    begin_run(2'b00, 3'd6, '0, 1'b1);
    code_ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0; code_ready = 1'b0;
    tests_run++;
    if (code_valid !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL stop_hs: valid=%b busy=%b wrap=%b, want 0 0 0", code_valid, busy, wrap);
    end
    begin_run(2'b00, 3'd0, '0, 1'b0);
    tests_run++;
    if (abc !== 3'd7) begin
      fails++;
      $display("FAIL stop_hs_count: abc=%b, want 111", abc);
    end
    halt();
    begin_run(2'b00, 3'd0, '0, 1'b0);
    tests_run++;
    if (abc !== 3'd7) begin
      fails++;
      $display("FAIL stop_nohs_count: abc=%b, want 111", abc);
    end
    code_ready = 1'b1;
    dwell = DWELL_W'(3);
    halt();
    begin_run(2'b00, 3'd7, DWELL_W'(3), 1'b1);
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    tests_run++;
    if (code_valid !== 1'b0 || wrap !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stop_dwell_enter: valid=%b wrap=%b busy=%b, want 0 1 1", code_valid, wrap, busy);
    end
    halt();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (code_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL stop_dwell[%0d]: valid=%b busy=%b, want 0 0", i, code_valid, busy);
      end
      tick();
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL start_stop_idle: busy=%b valid=%b, want 0 0", busy, code_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0]         m;
    logic [2:0]         cnt, expc;
    logic [DWELL_W-1:0] d;
    logic               exp_wrap, await_gap;
    int                 k, hs, gap, cyc;
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 2));
      cnt = 3'($urandom_range(0, 7));
      d = DWELL_W'($urandom_range(0, 3));
      k = int'($urandom_range(3, 14));
      hs = 0; gap = 0; cyc = 0; exp_wrap = 1'b0; await_gap = 1'b0;
      begin_run(m, cnt, d, 1'b1);
      while (hs < k && cyc < 300) begin
        expc = (m == 2'b10) ? gray3(cnt) : cnt;
        tests_run++;
        if (wrap !== exp_wrap || busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL rand%0d_flags: wrap=%b busy=%b done=%b, want %b 1 0",
                   r, wrap, busy, done, exp_wrap);
        end
        exp_wrap = 1'b0;
        if (code_valid === 1'b1) begin
          tests_run++;
          if (abc !== expc || (await_gap && gap != int'(d))) begin
            fails++;
            $display("FAIL rand%0d_offer: abc=%b gap=%0d, want %b gap %0d",
                     r, abc, gap, expc, d);
          end
          await_gap = 1'b0;
        end else begin
          gap++;
        end
        code_ready = ($urandom_range(0, 3) != 0);
        if (code_valid === 1'b1 && code_ready) begin
          exp_wrap = (m == 2'b01) ? (cnt == 3'd0) : (cnt == 3'd7);
          cnt = (m == 2'b01) ? cnt - 3'd1 : cnt + 3'd1;
          hs++; gap = 0; await_gap = 1'b1;
        end
        tick();
        cyc++;
      end
      tests_run++;
      if (hs < k || wrap !== exp_wrap) begin
        fails++;
        $display("FAIL rand%0d_end: transfers=%0d wrap=%b, want %0d %b", r, hs, wrap, k, exp_wrap);
      end
      halt();
      tests_run++;
      if (busy !== 1'b0 || code_valid !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_stop: busy=%b valid=%b, want 0 0", r, busy, code_valid);
      end
    end
  endtask

`ifdef SEQ_SKIP_EN
  task automatic test_skip();
    int exp_seq[7] = '{0, 2, 4, 5, 6, 7, 0};
    skip_mask = 8'h0A;
    code_ready = 1'b1;
    begin_run(2'b00, 3'd0, '0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (code_valid !== 1'b1 || abc !== 3'(exp_seq[i]) || wrap !== (i == 6)) begin
        fails++;
        $display("FAIL skip[%0d]: valid=%b abc=%b wrap=%b, want 1 %b %b",
                 i, code_valid, abc, wrap, 3'(exp_seq[i]), (i == 6));
      end
      if (i < 6) tick();
    end
    halt();
    skip_mask = 8'hFF;
    begin_run(2'b00, 3'd0, '0, 1'b0);
    tests_run++;
    if (busy !== 1'b0 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL skip_all: busy=%b valid=%b, want 0 0", busy, code_valid);
    end
    skip_mask = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_bin_up();
    test_gray_dwell();
    test_down_stall();
    test_single_pass();
    test_stop();
    test_random();
`ifdef SEQ_SKIP_EN
    test_skip();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
